// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Main control FSM for the multicycle MIPS datapath. Sequences fetch,
//   decode, execute, memory and writeback for R-type, lw, sw, beq and j.
//   Waits on a variable-latency memory, detects memory timeouts and illegal
//   opcodes, and counts retired instructions.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   opcode[5:0]     instruction[31:26] from the instruction register
//   zero            ALU zero flag (gates the branch PC write)
//   mem_ready       memory access completes this cycle
//   aluop[1:0]      00 add, 01 sub, 10 R-type funct, 11 unknown
//   alusrca         0 = PC, 1 = register A
//   alusrcb[1:0]    00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm << 2
//   iord            memory address: 0 = PC, 1 = ALUOut
//   memread/memwrite memory strobes
//   irwrite         load the instruction register
//   regdst          write register: 0 = rt, 1 = rd
//   memtoreg        write data: 0 = ALUOut, 1 = MDR
//   regwrite        register file write enable
//   pcwrite         PC write enable
//   pcsource[1:0]   next PC: 00 ALU, 01 ALUOut, 10 jump target
//   state[3:0]      current state code (debug)
//   illegal         sticky: illegal opcode decoded
//   timeout         sticky: memory wait exceeded TIMEOUT
//   instret         retired-instruction count (wraps)
//
// Memory handshake: in FETCH, MEMRD and MEMWR the strobe is held while
// mem_ready is low; the access completes on the cycle mem_ready is high,
// and the FSM advances on the following clock edge.
module mips_multicycle_ctrl #(
   parameter int TIMEOUT   = 15,
   parameter int CNT_W     = 4,
   parameter int INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [5:0]           opcode,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic [1:0]           aluop,
   output logic                 alusrca,
   output logic [1:0]           alusrcb,
   output logic                 iord,
   output logic                 memread,
   output logic                 memwrite,
   output logic                 irwrite,
   output logic                 regdst,
   output logic                 memtoreg,
   output logic                 regwrite,
   output logic                 pcwrite,
   output logic [1:0]           pcsource,
   output logic [3:0]           state,
   output logic                 illegal,
   output logic                 timeout,
   output logic [INSTRET_W-1:0] instret
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ERROR  = 4'd15
   } state_t;

   localparam logic [CNT_W-1:0]     TMO  = CNT_W'(TIMEOUT);
   localparam logic [INSTRET_W-1:0] ONE  = INSTRET_W'(1);

   state_t           st;
   logic [CNT_W-1:0] wcnt;
   logic             wait_state;
   logic             expired;

   assign wait_state = (st == S_FETCH) || (st == S_MEMRD) || (st == S_MEMWR);
   // Counter already holds TIMEOUT waits and memory is still not ready:
   // this cycle would be wait number TIMEOUT+1, so give up.
   assign expired    = wait_state && !mem_ready && (wcnt == TMO);
   assign state      = st;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st      <= S_FETCH;
         wcnt    <= '0;
         illegal <= 1'b0;
         timeout <= 1'b0;
         instret <= '0;
      end else begin
         // Only a continued wait keeps counting; every exit (or any other
         // state) leaves it at zero, so each wait state is entered with 0.
         if (wait_state && !mem_ready && !expired) wcnt <= wcnt + 1'b1;
         else                                      wcnt <= '0;

         unique case (st)
            S_FETCH: begin
               if (expired) begin
                  st      <= S_ERROR;
                  timeout <= 1'b1;
               end else if (mem_ready) begin
                  st <= S_DECODE;
               end
            end
            S_DECODE: begin
               unique case (opcode)
                  6'b000000:            st <= S_EXEC;
                  6'b100011, 6'b101011: st <= S_MEMADR;
                  6'b000100:            st <= S_BRANCH;
                  6'b000010:            st <= S_JUMP;
                  default: begin
                     st      <= S_ERROR;
                     illegal <= 1'b1;
                  end
               endcase
            end
            S_MEMADR: st <= (opcode == 6'b100011) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
               if (expired) begin
                  st      <= S_ERROR;
                  timeout <= 1'b1;
               end else if (mem_ready) begin
                  st <= S_MEMWB;
               end
            end
            S_MEMWR: begin
               if (expired) begin
                  st      <= S_ERROR;
                  timeout <= 1'b1;
               end else if (mem_ready) begin
                  st      <= S_FETCH;
                  instret <= instret + ONE;
               end
            end
            S_EXEC:  st <= S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: begin
               st      <= S_FETCH;
               instret <= instret + ONE;
            end
            S_ERROR: st <= S_ERROR;
            default: st <= S_ERROR;
         endcase
      end
   end

   always_comb begin
      aluop    = 2'b00;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      iord     = 1'b0;
      memread  = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      regwrite = 1'b0;
      pcwrite  = 1'b0;
      pcsource = 2'b00;
      unique case (st)
         S_FETCH: begin
            memread = 1'b1;
            alusrcb = 2'b01;
            irwrite = mem_ready;
            pcwrite = mem_ready;
         end
         S_DECODE: alusrcb = 2'b11;
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD: begin
            memread = 1'b1;
            iord    = 1'b1;
         end
         S_MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         S_MEMWR: begin
            memwrite = 1'b1;
            iord     = 1'b1;
         end
         S_EXEC: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
         end
         S_ALUWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
         end
         S_BRANCH: begin
            alusrca  = 1'b1;
            aluop    = 2'b01;
            pcsource = 2'b01;
            pcwrite  = zero;
         end
         S_JUMP: begin
            pcwrite  = 1'b1;
            pcsource = 2'b10;
         end
         S_ERROR: aluop = 2'b11;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl.
//   Driver tasks issue whole instructions (opcode class, fetch/memory wait
//   counts, branch condition). For every cycle they drive, the expected
//   control word is pushed into exp_q; a monitor on the falling edge pops and
//   compares against the DUT outputs.
module tb_mips_multicycle_ctrl;

   localparam int TMO = 15;

   // state codes
   localparam int P_FETCH  = 0;
   localparam int P_DECODE = 1;
   localparam int P_MEMADR = 2;
   localparam int P_MEMRD  = 3;
   localparam int P_MEMWB  = 4;
   localparam int P_MEMWR  = 5;
   localparam int P_EXEC   = 6;
   localparam int P_ALUWB  = 7;
   localparam int P_BRANCH = 8;
   localparam int P_JUMP   = 9;
   localparam int P_ERROR  = 15;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [5:0]  opcode = '0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic [1:0]  aluop, alusrcb, pcsource;
   logic        alusrca, iord, memread, memwrite, irwrite, regdst;
   logic        memtoreg, regwrite, pcwrite, illegal, timeout;
   logic [3:0]  state;
   logic [31:0] instret;

   mips_multicycle_ctrl #(.TIMEOUT(TMO), .CNT_W(4), .INSTRET_W(32)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .aluop(aluop), .alusrca(alusrca), .alusrcb(alusrcb), .iord(iord),
      .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
      .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
      .pcwrite(pcwrite), .pcsource(pcsource), .state(state),
      .illegal(illegal), .timeout(timeout), .instret(instret)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  state;
      logic [1:0]  aluop;
      logic        alusrca;
      logic [1:0]  alusrcb;
      logic        iord;
      logic        memread;
      logic        memwrite;
      logic        irwrite;
      logic        regdst;
      logic        memtoreg;
      logic        regwrite;
      logic        pcwrite;
      logic [1:0]  pcsource;
      logic        illegal;
      logic        timeout;
      logic [31:0] instret;
   } rec_t;
   localparam int RW = $bits(rec_t);

   logic [RW-1:0] exp_q[$];
   int tests = 0;
   int fails = 0;

   // reference model state (architectural view)
   int m_instret = 0;
   bit m_ill = 1'b0;
   bit m_to  = 1'b0;

   // Expected control word for one cycle spent in phase ph.
   function automatic rec_t expect_rec(int ph, logic mr, logic z);
      rec_t r;
      r = '0;
      r.state   = 4'(ph);
      r.illegal = m_ill;
      r.timeout = m_to;
      r.instret = 32'(m_instret);
      case (ph)
         P_FETCH:  begin r.memread = 1; r.alusrcb = 2'b01; r.irwrite = mr; r.pcwrite = mr; end
         P_DECODE: r.alusrcb = 2'b11;
         P_MEMADR: begin r.alusrca = 1; r.alusrcb = 2'b10; end
         P_MEMRD:  begin r.memread = 1; r.iord = 1; end
         P_MEMWB:  begin r.regwrite = 1; r.memtoreg = 1; end
         P_MEMWR:  begin r.memwrite = 1; r.iord = 1; end
         P_EXEC:   begin r.alusrca = 1; r.aluop = 2'b10; end
         P_ALUWB:  begin r.regwrite = 1; r.regdst = 1; end
         P_BRANCH: begin r.alusrca = 1; r.aluop = 2'b01; r.pcsource = 2'b01; r.pcwrite = z; end
         P_JUMP:   begin r.pcwrite = 1; r.pcsource = 2'b10; end
         P_ERROR:  r.aluop = 2'b11;
         default:  ;
      endcase
      return r;
   endfunction

   // One cycle: drive inputs, record expectation, advance to just after the edge.
   task automatic step(int ph, logic mr, logic z);
      mem_ready = mr;
      zero      = z;
      exp_q.push_back(expect_rec(ph, mr, z));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      mem_ready = 1'b0;
      zero      = 1'b0;
      m_instret = 0;
      m_ill     = 1'b0;
      m_to      = 1'b0;
      exp_q.push_back(expect_rec(P_FETCH, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // A memory phase with 'waits' not-ready cycles before the ready cycle.
   // More than TMO waits means the access is abandoned.
   task automatic mem_phase(int ph, int waits, output bit ok);
      for (int i = 0; i < waits && i <= TMO; i++) step(ph, 1'b0, 1'($urandom_range(0, 1)));
      if (waits > TMO) begin
         m_to = 1'b1;
         ok   = 1'b0;
      end else begin
         step(ph, 1'b1, 1'($urandom_range(0, 1)));
         ok = 1'b1;
      end
   endtask

   task automatic error_hold(int n);
      for (int i = 0; i < n; i++) step(P_ERROR, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic run_instr(logic [5:0] op, int fw, int mw, logic z);
      bit ok;
      opcode = op;
      mem_phase(P_FETCH, fw, ok);
      if (!ok) begin
         error_hold(4);
         do_reset();
         return;
      end
      step(P_DECODE, rnd(), rnd());
      case (op)
         OP_R: begin
            step(P_EXEC, rnd(), rnd());
            step(P_ALUWB, rnd(), rnd());
            m_instret++;
         end
         OP_LW, OP_SW: begin
            step(P_MEMADR, rnd(), rnd());
            if (op == OP_LW) begin
               mem_phase(P_MEMRD, mw, ok);
               if (ok) begin
                  step(P_MEMWB, rnd(), rnd());
                  m_instret++;
               end
            end else begin
               mem_phase(P_MEMWR, mw, ok);
               if (ok) m_instret++;
            end
            if (!ok) begin
               error_hold(4);
               do_reset();
            end
         end
         OP_BEQ: begin
            step(P_BRANCH, rnd(), z);
            m_instret++;
         end
         OP_J: begin
            step(P_JUMP, rnd(), rnd());
            m_instret++;
         end
         default: begin
            m_ill = 1'b1;
            error_hold(5);
            do_reset();
         end
      endcase
   endtask

   function automatic logic [5:0] rand_illegal();
      logic [5:0] o;
      do o = 6'($urandom_range(0, 63));
      while (o == OP_R || o == OP_LW || o == OP_SW || o == OP_BEQ || o == OP_J);
      return o;
   endfunction

   function automatic int rand_wait();
      if ($urandom_range(0, 9) == 0) return $urandom_range(14, 17);
      return $urandom_range(0, 3);
   endfunction

   // monitor / scoreboard
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         rec_t e, a;
         e = exp_q.pop_front();
         a.state = state;     a.aluop = aluop;       a.alusrca = alusrca;
         a.alusrcb = alusrcb; a.iord = iord;         a.memread = memread;
         a.memwrite = memwrite; a.irwrite = irwrite; a.regdst = regdst;
         a.memtoreg = memtoreg; a.regwrite = regwrite; a.pcwrite = pcwrite;
         a.pcsource = pcsource; a.illegal = illegal; a.timeout = timeout;
         a.instret = instret;
         tests++;
         if (a !== e) begin
            fails++;
            $display("FAIL ctrl_word t=%0t state got %0d exp %0d, word got %h exp %h, instret got %0d exp %0d",
                     $time, a.state, e.state, a, e, a.instret, e.instret);
         end
      end
   end

   initial begin
      logic [5:0] op;
      int sel;
      @(posedge clk);
      #1;
      do_reset();

      // directed cases
      run_instr(OP_R, 0, 0, 1'b0);
      run_instr(OP_LW, 0, 3, 1'b0);
      run_instr(OP_SW, 2, 0, 1'b0);
      run_instr(OP_BEQ, 0, 0, 1'b1);
      run_instr(OP_BEQ, 1, 0, 1'b0);
      run_instr(OP_J, 0, 0, 1'b0);
      run_instr(OP_LW, 15, 15, 1'b0);   // maximum tolerated waits
      opcode = 6'b111111;               // illegal opcode, long ERROR hold
      begin
         bit ok;
         mem_phase(P_FETCH, 0, ok);
         step(P_DECODE, 1'b1, 1'b0);
         m_ill = 1'b1;
         error_hold(20);
         do_reset();
      end
      run_instr(OP_R, 16, 0, 1'b0);     // fetch timeout
      run_instr(OP_LW, 0, 16, 1'b0);    // load timeout
      run_instr(OP_R, 0, 0, 1'b0);
      run_instr(OP_SW, 0, 17, 1'b0);    // store timeout
      run_instr(OP_J, 0, 0, 1'b0);
      // reset in the middle of a load
      opcode = OP_LW;
      step(P_FETCH, 1'b1, 1'b0);
      step(P_DECODE, 1'b0, 1'b0);
      step(P_MEMADR, 1'b0, 1'b0);
      do_reset();

      // randomized instruction stream
      for (int n = 0; n < 150; n++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1:    op = OP_R;
            2, 3:    op = OP_LW;
            4, 5:    op = OP_SW;
            6:       op = OP_BEQ;
            7:       op = OP_J;
            8:       op = rand_illegal();
            default: op = 6'($urandom_range(0, 63));
         endcase
         run_instr(op, rand_wait(), rand_wait(), rnd());
      end

      @(negedge clk);
      #1;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL queue_drain got %0d entries left, need 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback for R-type, lw, sw, beq and j.
- Drives aluop into the existing ALU-control decoder, plus all mux selects and write enables.
- Handshakes with a variable-latency memory, detects memory timeouts and illegal opcodes, and counts retired instructions.

Parameters:
- TIMEOUT, 15: maximum consecutive wait cycles (mem_ready low) allowed in one memory state.
- CNT_W, 4: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.
- INSTRET_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst  in  1  reset, asynchronous, active-high.
- opcode  in  6  instruction[31:26], from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- aluop  out  2  00 add, 01 sub, 10 R-type funct, 11 unknown.
- alusrca  out  1  0 = PC, 1 = register A.
- alusrcb  out  2  00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- iord  out  1  memory address: 0 = PC, 1 = ALUOut.
- memread  out  1  memory read strobe.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  load the instruction register.
- regdst  out  1  write register: 0 = rt, 1 = rd.
- memtoreg  out  1  write data: 0 = ALUOut, 1 = MDR.
- regwrite  out  1  register file write enable.
- pcwrite  out  1  PC write enable.
- pcsource  out  2  next PC: 00 = ALU, 01 = ALUOut, 10 = jump target.
- state  out  4  current state code, for debug.
- illegal  out  1  sticky: an illegal opcode was decoded.
- timeout  out  1  sticky: a memory wait exceeded TIMEOUT.
- instret  out  INSTRET_W  retired-instruction count.

Behaviour:
- Clock and reset: one clock domain. rst asynchronous, active-high.
- Reset values: state=FETCH(0), wait counter=0, illegal=0, timeout=0, instret=0.
- Outputs are combinational from state, mem_ready and zero (Moore, except the gated enables listed below).
- Output default in every state: all enables 0, all selects 0, aluop=00.
- Consequence at reset: outputs are FETCH values, i.e. memread=1, alusrcb=01, everything else 0 while mem_ready=0.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ERROR 15.
- State outputs and transitions:
  - FETCH: memread=1, alusrcb=01, aluop=00, irwrite=mem_ready, pcwrite=mem_ready. Goes to DECODE when mem_ready=1, else stays.
  - DECODE: alusrcb=11, aluop=00. Next state by opcode:
    - 000000 -> EXEC
    - 100011 or 101011 -> MEMADR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - any other -> ERROR, and set illegal.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD if opcode=100011, else MEMWR.
  - MEMRD: memread=1, iord=1. Goes to MEMWB when mem_ready=1.
  - MEMWB: regwrite=1, memtoreg=1, regdst=0. Goes to FETCH.
  - MEMWR: memwrite=1, iord=1. Goes to FETCH when mem_ready=1.
  - EXEC: alusrca=1, alusrcb=00, aluop=10. Goes to ALUWB.
  - ALUWB: regwrite=1, regdst=1, memtoreg=0. Goes to FETCH.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsource=01, pcwrite=zero. Goes to FETCH.
  - JUMP: pcwrite=1, pcsource=10. Goes to FETCH.
  - ERROR: aluop=11, all enables 0. Stays until rst.
- Wait counter (FETCH, MEMRD, MEMWR only):
  - Cleared on entry to each of these states.
  - Increments each cycle the FSM is in one of them with mem_ready=0.
  - If the counter equals TIMEOUT and mem_ready=0: go to ERROR and set timeout.
  - If mem_ready=1 on the same cycle the counter equals TIMEOUT, mem_ready wins and the normal transition is taken.
  - Hence up to TIMEOUT wait cycles are tolerated; a response on wait cycle TIMEOUT+1 is an error.
  - In the timeout cycle itself, memread/memwrite stay asserted; irwrite and pcwrite are 0.
- instret:
  - Increments by 1 on each clock edge leaving MEMWB, ALUWB, BRANCH or JUMP, and on the edge leaving MEMWR with mem_ready=1.
  - Wraps modulo 2^INSTRET_W.
  - Holds in ERROR.
- illegal and timeout are sticky; only rst clears them.
- rst asserted mid-instruction: immediate return to FETCH with all counters and flags cleared.
- Latencies with zero-wait memory:
  - R-type 4 cycles, lw 5, sw 4, beq 3, j 3.
  - Each wait cycle adds 1 cycle.

Test Plan:
- rst pulse, mem_ready=0 -> state=0, memread=1, alusrcb=01, irwrite=0, pcwrite=0, instret=0, illegal=0, timeout=0.
- opcode=000000, mem_ready always 1 -> states 0,1,6,7,0. aluop=10 in EXEC; regwrite=1 with regdst=1 in ALUWB; instret=1 after 4 cycles.
- opcode=100011, mem_ready low for 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4,0. memtoreg=1 in MEMWB; instret increments once.
- opcode=000100: with zero=1, pcwrite=1 and pcsource=01 in BRANCH; repeat with zero=0, pcwrite=0. Both cases: aluop=01, instret increments.
- opcode=111111 -> DECODE then ERROR. Then state=15, aluop=11, illegal=1, all enables 0, held for 20 cycles; rst returns to FETCH with illegal=0.
- Memory timing in FETCH with TIMEOUT=15:
  - mem_ready held 0 -> ERROR entered after 16 cycles in FETCH, timeout=1.
  - Separate run with mem_ready asserted on the 16th FETCH cycle -> DECODE, no timeout.
